// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-granular sharing of one UART tx byte port among NUM_REQ requesters.
// One cycle from request to grant; the owner's byte path is combinational, so req_ready follows tx_ready.
module uart_tx_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int MAX_BURST  = 16,
   parameter int GAP_CYCLES = 0
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_REQ-1:0]     req_valid,
   input  logic [8*NUM_REQ-1:0]   req_data,
   input  logic [NUM_REQ-1:0]     req_last,
   output logic [NUM_REQ-1:0]     req_ready,
   output logic [7:0]             tx_data,
   output logic                   tx_valid,
   input  logic                   tx_ready,
   input  logic                   tx_idle,
   output logic [NUM_REQ-1:0]     grant,
   output logic                   busy,
   output logic [15:0]            pkt_count
);

   localparam int OW = $clog2(NUM_REQ);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_GAP  = 2'd2
   } state_e;

   state_e        state_q, state_d;
   logic [OW-1:0] owner_q, owner_d;
   logic [OW-1:0] rr_ptr_q, rr_ptr_d;
   logic [15:0]   burst_cnt_q, burst_cnt_d;
   logic [15:0]   gap_cnt_q, gap_cnt_d;
   logic [15:0]   pkt_count_q, pkt_count_d;

   logic [7:0]    req_byte [NUM_REQ];
   logic [OW-1:0] pick;
   logic          any_req;
   logic          own_valid;
   logic          own_last;
   logic          xfer;
   logic          burst_hit;
   logic          pkt_end;
   logic [OW-1:0] next_owner;
   logic          sending;

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_byte
      assign req_byte[g] = req_data[8*g +: 8];
   end

   // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
   always_comb begin
      int            idx;
      logic [OW-1:0] idx_w;
      idx     = 0;
      idx_w   = '0;
      pick    = rr_ptr_q;
      any_req = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx   = (int'(rr_ptr_q) + i) % NUM_REQ;
         idx_w = OW'(idx);
         if (!any_req && req_valid[idx_w]) begin
            pick    = idx_w;
            any_req = 1'b1;
         end
      end
   end

   assign own_valid  = req_valid[owner_q];
   assign own_last   = req_last[owner_q];
   assign xfer       = (state_q == ST_SEND) && own_valid && tx_ready;
   assign burst_hit  = (MAX_BURST != 0) && ((burst_cnt_q + 16'd1) == 16'(MAX_BURST));
   assign pkt_end    = xfer && (own_last || burst_hit);
   assign next_owner = (owner_q == OW'(NUM_REQ - 1)) ? '0 : owner_q + OW'(1);

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      rr_ptr_d    = rr_ptr_q;
      burst_cnt_d = burst_cnt_q;
      gap_cnt_d   = gap_cnt_q;
      pkt_count_d = pkt_count_q;
      case (state_q)
         ST_IDLE: begin
            if (any_req) begin
               owner_d     = pick;
               burst_cnt_d = '0;
               state_d     = ST_SEND;
            end
         end
         ST_SEND: begin
            if (xfer) begin
               burst_cnt_d = burst_cnt_q + 16'd1;
            end
            if (pkt_end) begin
               pkt_count_d = pkt_count_q + 16'd1;
               rr_ptr_d    = next_owner;
               gap_cnt_d   = 16'(GAP_CYCLES);
               state_d     = ST_GAP;
            end
         end
         ST_GAP: begin
            // Even with no gap configured, wait for the last byte to leave the wire.
            if (gap_cnt_q != 16'd0) begin
               gap_cnt_d = gap_cnt_q - 16'd1;
            end else if (tx_idle) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         owner_q     <= '0;
         rr_ptr_q    <= '0;
         burst_cnt_q <= '0;
         gap_cnt_q   <= '0;
         pkt_count_q <= '0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         rr_ptr_q    <= rr_ptr_d;
         burst_cnt_q <= burst_cnt_d;
         gap_cnt_q   <= gap_cnt_d;
         pkt_count_q <= pkt_count_d;
      end
   end

   // Reset also masks the byte path, so no requester loses a byte to a dropped grant.
   assign sending = (state_q == ST_SEND) && !rst;

   always_comb begin
      grant     = '0;
      req_ready = '0;
      tx_valid  = 1'b0;
      tx_data   = 8'h00;
      if (sending) begin
         grant[owner_q]     = 1'b1;
         req_ready[owner_q] = tx_ready;
         tx_valid           = own_valid;
         tx_data            = req_byte[owner_q];
      end
   end

   assign busy      = (state_q != ST_IDLE) && !rst;
   assign pkt_count = pkt_count_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench: main instance (4 requesters, burst 2, no gap) and a gap instance (2 requesters, gap 5).
module tb_uart_tx_arbiter;

   localparam int NR = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst;
   logic [NR-1:0]     req_valid, req_last, req_ready, grant;
   logic [8*NR-1:0]   req_data;
   logic [7:0]        tx_data;
   logic              tx_valid, tx_ready, tx_idle, busy;
   logic [15:0]       pkt_count;

   logic [1:0]        g_req_valid, g_req_last, g_req_ready, g_grant;
   logic [15:0]       g_req_data;
   logic [7:0]        g_tx_data;
   logic              g_tx_valid, g_tx_ready, g_tx_idle, g_busy;
   logic [15:0]       g_pkt_count;

   uart_tx_arbiter #(.NUM_REQ(NR), .MAX_BURST(2), .GAP_CYCLES(0)) u_dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_idle(tx_idle),
      .grant(grant), .busy(busy), .pkt_count(pkt_count)
   );

   uart_tx_arbiter #(.NUM_REQ(2), .MAX_BURST(0), .GAP_CYCLES(5)) u_gap (
      .clk(clk), .rst(rst),
      .req_valid(g_req_valid), .req_data(g_req_data), .req_last(g_req_last), .req_ready(g_req_ready),
      .tx_data(g_tx_data), .tx_valid(g_tx_valid), .tx_ready(g_tx_ready), .tx_idle(g_tx_idle),
      .grant(g_grant), .busy(g_busy), .pkt_count(g_pkt_count)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Per-requester byte queues: {last, data}.
   logic [8:0]    mem [NR][16];
   int            head [NR];
   int            tail [NR];
   logic [NR-1:0] hold;
   int            cyc, rdy_period, idle_cnt;
   logic [7:0]    log_dat [64];
   int            log_n, last_xfer_cyc, s_cyc;
   logic [NR-1:0] s_grant, s_ready, grant_or;
   logic          s_busy, s_valid;
   logic [7:0]    s_data;
   int            stall_bad, fall_gap;

   task automatic push(input int r, input logic [7:0] d, input logic l);
      mem[r][tail[r]] = {l, d};
      tail[r]++;
   endtask

   // One clock: drive at negedge, sample 1ns later, retire accepted bytes, advance to next negedge.
   task automatic cycle();
      for (int i = 0; i < NR; i++) begin
         req_valid[i]       = (head[i] != tail[i]) && !hold[i];
         req_last[i]        = req_valid[i] & mem[i][head[i]][8];
         req_data[8*i +: 8] = req_valid[i] ? mem[i][head[i]][7:0] : 8'h00;
      end
      tx_ready = (rdy_period <= 1) ? 1'b1 : ((cyc % rdy_period) == 0);
      tx_idle  = (idle_cnt == 0);
      #1;
      s_cyc    = cyc;
      s_grant  = grant;
      s_ready  = req_ready;
      s_busy   = busy;
      s_valid  = tx_valid;
      s_data   = tx_data;
      grant_or = grant_or | grant;
      if (tx_valid && tx_ready) begin
         if (log_n < 64) log_dat[log_n] = tx_data;
         log_n++;
         last_xfer_cyc = cyc;
         idle_cnt      = 3;
      end else if (idle_cnt > 0) begin
         idle_cnt--;
      end
      for (int i = 0; i < NR; i++) begin
         if (req_valid[i] && req_ready[i]) head[i]++;
      end
      @(negedge clk);
      cyc++;
   endtask

   task automatic run_until(input int n, input int budget, input string tag);
      int b;
      b = budget;
      while (log_n < n && b > 0) begin
         cycle();
         b--;
      end
      check_eq({tag, "_count"}, log_n, n);
   endtask

   task automatic wait_idle(input int budget, input string tag);
      int b;
      b = budget;
      do begin
         cycle();
         b--;
      end while (s_busy && b > 0);
      check_eq({tag, "_idle"}, {31'd0, s_busy}, 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int         gn;
      int         gt [2];
      logic [7:0] gd [2];
      logic [1:0] clr;
      int         g_noise;

      rst = 1'b1;
      req_valid = '0; req_last = '0; req_data = '0; tx_ready = 1'b1; tx_idle = 1'b1;
      g_req_valid = '0; g_req_last = '0; g_req_data = '0; g_tx_ready = 1'b1; g_tx_idle = 1'b1;
      hold = '0; cyc = 0; rdy_period = 1; idle_cnt = 0; log_n = 0; last_xfer_cyc = 0;
      grant_or = '0; s_cyc = 0;
      for (int i = 0; i < NR; i++) begin
         head[i] = 0;
         tail[i] = 0;
      end

      // All four requesters valid through reset and at its release.
      for (int i = 0; i < NR; i++) push(i, 8'hA0 + 8'(i), 1'b1);
      cycle();
      cycle();
      check_eq("rst_grant", 32'(s_grant), 32'h0);
      check_eq("rst_ready", 32'(s_ready), 32'h0);
      check_eq("rst_valid", 32'(s_valid), 32'h0);
      check_eq("rst_data",  32'(s_data),  32'h0);
      check_eq("rst_busy",  32'(s_busy),  32'h0);
      check_eq("rst_pkt",   32'(pkt_count), 32'h0);
      rst = 1'b0;

      run_until(4, 120, "rr");
      for (int i = 0; i < 4; i++) check_eq($sformatf("rr_byte%0d", i), 32'(log_dat[i]), 32'hA0 + i);
      wait_idle(40, "rr");
      check_eq("rr_pkt", 32'(pkt_count), 32'd4);

      // "Hi" from requester 0, transmitter ready every third cycle.
      log_n = 0; rdy_period = 3;
      push(0, 8'h48, 1'b0);
      push(0, 8'h69, 1'b1);
      cycle();
      check_eq("hi_lat_idle", 32'(s_grant), 32'h0);
      grant_or = '0;
      cycle();
      check_eq("hi_lat_grant", 32'(s_grant), 32'h1);
      run_until(2, 60, "hi");
      check_eq("hi_byte0", 32'(log_dat[0]), 32'h48);
      check_eq("hi_byte1", 32'(log_dat[1]), 32'h69);
      wait_idle(40, "hi");
      check_eq("hi_grant_or", 32'(grant_or), 32'h1);
      check_eq("hi_pkt", 32'(pkt_count), 32'd5);
      fall_gap = s_cyc - last_xfer_cyc;
      check_eq("hi_busy_fall", fall_gap, 32'd5);
      rdy_period = 1;

      // Burst cap of 2 interleaves requester 2 into requester 1's packet.
      log_n = 0;
      for (int i = 1; i <= 5; i++) push(1, 8'(i), (i == 5));
      push(2, 8'h20, 1'b1);
      run_until(6, 200, "burst");
      check_eq("burst_b0", 32'(log_dat[0]), 32'h01);
      check_eq("burst_b1", 32'(log_dat[1]), 32'h02);
      check_eq("burst_b2", 32'(log_dat[2]), 32'h20);
      check_eq("burst_b3", 32'(log_dat[3]), 32'h03);
      check_eq("burst_b4", 32'(log_dat[4]), 32'h04);
      check_eq("burst_b5", 32'(log_dat[5]), 32'h05);
      wait_idle(40, "burst");
      check_eq("burst_pkt", 32'(pkt_count), 32'd9);

      // Owner stalls mid-packet while requester 3 waits.
      log_n = 0;
      push(0, 8'h10, 1'b0);
      push(0, 8'h11, 1'b1);
      run_until(1, 40, "stall_first");
      hold[0] = 1'b1;
      push(3, 8'h30, 1'b1);
      stall_bad = 0;
      for (int k = 0; k < 20; k++) begin
         cycle();
         if (s_grant !== 4'b0001 || s_ready[3] !== 1'b0) stall_bad++;
      end
      check_eq("stall_hold", stall_bad, 32'd0);
      check_eq("stall_nobyte", log_n, 32'd1);
      hold[0] = 1'b0;
      run_until(3, 80, "stall");
      check_eq("stall_b1", 32'(log_dat[1]), 32'h11);
      check_eq("stall_b2", 32'(log_dat[2]), 32'h30);
      wait_idle(40, "stall");
      check_eq("stall_pkt", 32'(pkt_count), 32'd11);

      // Reset in the middle of requester 2's packet with rr_ptr moved off 0.
      log_n = 0;
      push(1, 8'h15, 1'b1);
      run_until(1, 40, "rs_pre");
      wait_idle(40, "rs_pre");
      push(2, 8'h21, 1'b0);
      push(2, 8'h22, 1'b0);
      push(2, 8'h23, 1'b1);
      run_until(2, 40, "rs_mid");
      push(0, 8'h05, 1'b1);
      rst = 1'b1;
      cycle();
      check_eq("rs_during_valid", 32'(s_valid), 32'h0);
      rst = 1'b0;
      cycle();
      check_eq("rs_grant", 32'(s_grant), 32'h0);
      check_eq("rs_valid", 32'(s_valid), 32'h0);
      check_eq("rs_busy",  32'(s_busy),  32'h0);
      check_eq("rs_pkt",   32'(pkt_count), 32'h0);
      run_until(5, 100, "rs_post");
      check_eq("rs_b2", 32'(log_dat[2]), 32'h05);
      check_eq("rs_b3", 32'(log_dat[3]), 32'h22);
      check_eq("rs_b4", 32'(log_dat[4]), 32'h23);
      wait_idle(40, "rs_post");
      check_eq("rs_pkt_end", 32'(pkt_count), 32'd2);

      // Gap instance: two back-to-back one-byte packets, tx_idle held high.
      gn = 0; gt[0] = 0; gt[1] = 0; gd[0] = 8'h00; gd[1] = 8'h00; g_noise = 0;
      g_req_valid = 2'b11;
      g_req_last  = 2'b11;
      g_req_data  = {8'h88, 8'h77};
      for (int c = 0; c < 60 && gn < 2; c++) begin
         #1;
         if (g_tx_valid && g_tx_ready) begin
            gt[gn] = c;
            gd[gn] = g_tx_data;
            gn++;
         end else if (gn == 1 && (g_tx_valid || g_grant != 2'b00)) begin
            g_noise++;
         end
         clr = g_req_ready & g_req_valid;
         @(negedge clk);
         g_req_valid = g_req_valid & ~clr;
      end
      check_eq("gap_count", gn, 32'd2);
      check_eq("gap_b0", 32'(gd[0]), 32'h77);
      check_eq("gap_b1", 32'(gd[1]), 32'h88);
      check_eq("gap_low_cycles", gt[1] - gt[0] - 1, 32'd7);
      check_eq("gap_quiet", g_noise, 32'd0);
      check_eq("gap_pkt", 32'(g_pkt_count), 32'd2);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter between NUM_REQ byte-stream requesters, for example a debug printer, a checksum reporter and a command echo.
- Arbitration is round-robin at packet granularity; a packet ends on the byte flagged last.
- Sits between the requester blocks and the tx byte interface inside uart_top.
- Optionally inserts an idle gap between packets, and caps burst length so one requester cannot starve the others.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- MAX_BURST, 16, bytes per grant before forced rotation; 0 = unlimited (whole packet).
- GAP_CYCLES, 0, clk cycles of enforced idle after each grant ends, before re-arbitration.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset: one clock; reset is synchronous and active-high.
- req_valid  in  NUM_REQ  per-requester byte valid.
- req_data  in  8*NUM_REQ  byte for requester i at [8i+7:8i].
- req_last  in  NUM_REQ  byte is last of packet.
- req_ready  out  NUM_REQ  byte accepted this cycle.
- tx_data  out  8  byte to transmitter.
- tx_valid  out  1  byte offered to transmitter.
- tx_ready  in  1  transmitter accepts byte this cycle.
- tx_idle  in  1  transmitter shift register empty (tx o_idle).
- grant  out  NUM_REQ  one-hot current owner; 0 when none.
- busy  out  1  state != IDLE.
- pkt_count  out  16  completed grants, wraps at 0xFFFF->0.

Behaviour:
- Registered state: state {IDLE, SEND, GAP}, owner index, rr_ptr, burst_cnt, gap_cnt, pkt_count.
- Reset (synchronous, rst=1 at posedge): state=IDLE, owner=0, rr_ptr=0, burst_cnt=0, gap_cnt=0, pkt_count=0. Reset wins over any other event that cycle.
- Outputs during and after reset until arbitration: grant=0, busy=0, req_ready=0, tx_valid=0, tx_data=0.
- Reset mid-packet drops the grant. A byte in flight with tx_ready the same cycle is not counted.
- IDLE:
  - If any req_valid, pick the first set bit scanning from rr_ptr upward, modulo NUM_REQ.
  - Register the pick as owner, clear burst_cnt, go to SEND.
  - Arbitration latency is 1 cycle: a request seen at edge N is forwarded from cycle N+1.
  - If no req_valid, stay in IDLE.
- SEND outputs (combinational from registered owner):
  - grant = 1<<owner.
  - tx_valid = req_valid[owner].
  - tx_data = req_data[owner].
  - req_ready[owner] = tx_ready; all other req_ready bits = 0.
  - tx_data = 0 when not in SEND.
- SEND transfers: a transfer is req_valid[owner] && tx_ready. On each transfer, burst_cnt increments.
- SEND ends on a transfer with req_last[owner]=1, or on the MAX_BURST-th transfer when MAX_BURST != 0. On end:
  - pkt_count increments.
  - rr_ptr = (owner+1) mod NUM_REQ.
  - Go to GAP with gap_cnt=GAP_CYCLES.
- SEND stall: owner holding req_valid low keeps the grant indefinitely. There is no timeout, and other requesters wait.
- GAP:
  - grant=0, tx_valid=0, busy=1.
  - gap_cnt decrements to 0 while it is nonzero.
  - Go to IDLE when gap_cnt==0 and tx_idle==1. With GAP_CYCLES=0 this still waits for tx_idle, so a new grant starts only after the previous last byte has left the wire.
- Simultaneous requests from all requesters are served in rotation order starting at rr_ptr. The requester just served gets lowest priority next round.
- A requester that asserts valid during another's grant is served at the next arbitration, subject to rotation order.
- Burst-limited rotation: a packet cut by MAX_BURST resumes at that requester's next grant with no bytes lost or repeated. pkt_count counts grants, not packets.
- Protocol: req_data and req_last must be held while req_valid=1 && !req_ready. The arbiter never reorders bytes within a requester.

Test Plan:
- Single requester: req 0 sends "Hi" (0x48, last 0x69); tx_ready pulses every 3 cycles.
  -> tx sees 0x48 then 0x69; grant=0001 only in SEND; pkt_count=1; busy falls once tx_idle=1.
- All 4 requesters valid from reset release, each a 1-byte last packet 0xA0+i.
  -> tx order A0,A1,A2,A3; rr_ptr returns to 0; pkt_count=4.
- MAX_BURST=2: req 1 sends 5-byte packet 01..05, req 2 sends 1-byte 0x20 (last).
  -> order 01,02,20,03,04,05; pkt_count=4.
- GAP_CYCLES=5, tx_idle forced high: two back-to-back 1-byte packets.
  -> tx_valid low for at least 6 cycles between the two transfers (GAP 5 + IDLE arbitration 1).
- Owner stalls: req 0 drops valid for 20 cycles mid-packet while req 3 is valid.
  -> grant stays 0001; req_ready[3]=0 throughout; req 3 is granted only after req 0's last byte.
- rst=1 asserted in SEND mid-packet.
  -> next cycle grant=0, tx_valid=0, pkt_count=0, busy=0; re-arbitration starts from requester 0.
